pet_ce_gen: RTL

//  Parametrised clock-enable generator for the PET core: a pixel enable pair and a CPU enable.
//  CPU rate is selectable, with a tape-fast override, stall (drop or hold), and pause/single-step.

---
 rtl/pet_ce_gen_if.sv | 27 ++
 rtl/pet_ce_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/pet_ce_gen_if.sv
// Control and status bundle for the PET clock-enable generator.
// The master side drives the rate/stall/debug controls; the generator sits on the slave side.
interface pet_ce_gen_if #(
  parameter int RATE_W = 7,
  parameter int CNT_W  = 32
);
  logic [1:0]        speed_sel;
  logic              fast;
  logic              stall;
  logic              pause;
  logic              step;
  logic              ce_pix_p;
  logic              ce_pix_n;
  logic              ce_cpu;
  logic [RATE_W-1:0] rate_cur;
  logic [CNT_W-1:0]  cyc_cnt;

  modport master (
    output speed_sel, fast, stall, pause, step,
    input  ce_pix_p, ce_pix_n, ce_cpu, rate_cur, cyc_cnt
  );

  modport slave (
    input  speed_sel, fast, stall, pause, step,
    output ce_pix_p, ce_pix_n, ce_cpu, rate_cur, cyc_cnt
  );
endinterface

// File: rtl/pet_ce_gen.sv
// PET clock-enable generator: two-phase pixel enable plus a CPU enable with selectable
// rate, tape-fast override, stall hold/drop, pause/single-step and a CPU cycle counter.
module pet_ce_gen #(
  parameter int PIX_DIV    = 16,
  parameter int RATE_W     = 7,
  parameter int RATE0      = 111,
  parameter int RATE1      = 55,
  parameter int RATE2      = 27,
  parameter int RATE3      = 13,
  parameter int FAST_RATE  = 2,
  parameter int STALL_HOLD = 1,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  pet_ce_gen_if.slave bus
);
  localparam int PIX_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

  typedef logic [RATE_W-1:0] rate_t;

  localparam rate_t [3:0] RATE_TBL = {rate_t'(RATE3), rate_t'(RATE2),
                                      rate_t'(RATE1), rate_t'(RATE0)};

  logic [PIX_W-1:0] r_pix_div;
  rate_t            r_cpu_div;
  rate_t            r_rate_cur;
  logic             r_step_pend;
  logic             r_ce_pix_p;
  logic             r_ce_pix_n;
  logic             r_ce_cpu;
  logic [CNT_W-1:0] r_cyc_cnt;

  rate_t w_next_rate;
  logic  w_pix_last;
  logic  w_div_zero;
  logic  w_hold;
  logic  w_boundary;
  logic  w_issue;

  always_comb begin
    w_next_rate = bus.fast ? rate_t'(FAST_RATE) : RATE_TBL[bus.speed_sel];
    w_pix_last  = (r_pix_div == PIX_W'(PIX_DIV - 1));
    w_div_zero  = (r_cpu_div == '0);
    // Hold mode parks the divider on the pulse slot so the stalled pulse is only delayed.
    w_hold      = (STALL_HOLD != 0) && bus.stall && w_div_zero;
    w_boundary  = (r_cpu_div == r_rate_cur) && !w_hold;
    w_issue     = w_div_zero && !bus.stall && (!bus.pause || r_step_pend);
  end

  // Pixel divider and its two registered phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_div  <= '0;
      r_ce_pix_p <= 1'b0;
      r_ce_pix_n <= 1'b0;
    end else begin
      r_pix_div  <= w_pix_last ? '0 : r_pix_div + 1'b1;
      r_ce_pix_p <= (r_pix_div == '0);
      r_ce_pix_n <= (r_pix_div == PIX_W'(PIX_DIV / 2));
    end
  end

  // The rate is sampled only at the period boundary, so mid-period changes never bend a period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_div  <= '0;
      r_rate_cur <= rate_t'(RATE0);
    end else if (w_hold) begin
      r_cpu_div  <= r_cpu_div;
    end else if (w_boundary) begin
      r_cpu_div  <= '0;
      r_rate_cur <= w_next_rate;
    end else begin
      r_cpu_div  <= r_cpu_div + 1'b1;
    end
  end

  // A pending step survives stalls, collapses repeated steps, and dies with pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_pend <= 1'b0;
    end else if (!bus.pause) begin
      r_step_pend <= 1'b0;
    end else if (w_issue && r_step_pend) begin
      r_step_pend <= 1'b0;
    end else if (bus.step) begin
      r_step_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ce_cpu  <= 1'b0;
      r_cyc_cnt <= '0;
    end else begin
      r_ce_cpu  <= w_issue;
      if (w_issue) r_cyc_cnt <= r_cyc_cnt + 1'b1;
    end
  end

  assign bus.ce_pix_p = r_ce_pix_p;
  assign bus.ce_pix_n = r_ce_pix_n;
  assign bus.ce_cpu   = r_ce_cpu;
  assign bus.rate_cur = r_rate_cur;
  assign bus.cyc_cnt  = r_cyc_cnt;

  a_pix_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(r_ce_pix_p && r_ce_pix_n));

  a_div_in_range: assert property (@(posedge clk) disable iff (reset)
    r_cpu_div <= r_rate_cur);
endmodule
